// File: rtl/hex_ascii_streamer_pkg.sv
// Shared definitions for the hex ASCII streamer.
//   state_e  : streamer FSM states (idle, hex digits, carriage return, line feed)
//   ASCII_*  : character codes used when building output characters
package hex_ascii_streamer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHex,
    StCr,
    StLf
  } state_e;

  localparam int unsigned ASCII_CR = 13;
  localparam int unsigned ASCII_LF = 10;
  localparam int unsigned ASCII_0  = 48;
  localparam int unsigned ASCII_A  = 65;

endpackage

// File: rtl/nibble_ascii_lut.sv
// Combinational nibble to uppercase ASCII hex digit mapping.
//   nibble : 4-bit value 0..15
//   ascii  : '0'..'9' (48..57) or 'A'..'F' (65..70), ASCII_SIZE bits wide
module nibble_ascii_lut
  import hex_ascii_streamer_pkg::*;
#(
  parameter int unsigned ASCII_SIZE = 8
) (
  input  logic [3:0]            nibble,
  output logic [ASCII_SIZE-1:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) begin
      ascii = ASCII_SIZE'(ASCII_0 + 32'(nibble));
    end else begin
      ascii = ASCII_SIZE'(ASCII_A + 32'(nibble) - 32'd10);
    end
  end

endmodule

// File: rtl/hex_ascii_streamer.sv
// Prints a DATA_WIDTH-bit word as uppercase hex ASCII characters, MSB nibble first,
// optionally followed by CR LF, one character per accepted out_valid/out_ready handshake.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : word handshake (ready only while idle)
//   in_data             : word to print
//   out_valid/out_ready : character handshake toward the UART transmitter
//   out_char            : current character, held stable while stalled
//   busy                : a word is being streamed
//   done                : one-cycle pulse after the last character is accepted
// DATA_WIDTH must be a multiple of 4 and at least 8.
module hex_ascii_streamer
  import hex_ascii_streamer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned ASCII_SIZE  = 8,
  parameter bit          APPEND_CRLF = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [ASCII_SIZE-1:0] out_char,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned NumDigits = DATA_WIDTH / 4;
  localparam int unsigned CntW      = $clog2(NumDigits);
  localparam logic [CntW-1:0] LastCnt = CntW'(NumDigits - 1);

  state_e                state;
  // Holds the nibbles still to be shown after the one currently on out_char.
  logic [DATA_WIDTH-5:0] shift;
  logic [CntW-1:0]       cnt;
  logic [3:0]            lut_nibble;
  logic [ASCII_SIZE-1:0] lut_char;
  logic                  accept;

  assign in_ready = (state == StIdle);
  assign busy     = (state != StIdle);
  assign accept   = out_valid & out_ready;

  // The LUT looks one character ahead: the incoming word's top nibble while idle,
  // otherwise the next nibble to display once the current one is accepted.
  assign lut_nibble = (state == StIdle) ? in_data[DATA_WIDTH-1 -: 4]
                                        : shift[DATA_WIDTH-5 -: 4];

  nibble_ascii_lut #(
    .ASCII_SIZE(ASCII_SIZE)
  ) u_lut (
    .nibble(lut_nibble),
    .ascii (lut_char)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      shift     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_char  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            shift     <= in_data[DATA_WIDTH-5:0];
            cnt       <= LastCnt;
            out_valid <= 1'b1;
            out_char  <= lut_char;
            state     <= StHex;
          end
        end
        StHex: begin
          if (accept) begin
            if (cnt != '0) begin
              cnt      <= cnt - 1'b1;
              shift    <= shift << 4;
              out_char <= lut_char;
            end else if (APPEND_CRLF) begin
              out_char <= ASCII_SIZE'(ASCII_CR);
              state    <= StCr;
            end else begin
              out_valid <= 1'b0;
              out_char  <= '0;
              done      <= 1'b1;
              state     <= StIdle;
            end
          end
        end
        StCr: begin
          if (accept) begin
            out_char <= ASCII_SIZE'(ASCII_LF);
            state    <= StLf;
          end
        end
        StLf: begin
          if (accept) begin
            out_valid <= 1'b0;
            out_char  <= '0;
            done      <= 1'b1;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_ascii_streamer.sv
module tb_hex_ascii_streamer;

  localparam int unsigned W = 128;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid, busy, done;
  logic [7:0]   out_char;

  logic         n_in_valid, n_out_ready;
  logic [7:0]   n_in_data;
  logic         n_in_ready, n_out_valid, n_busy, n_done;
  logic [7:0]   n_out_char;

  int n_vec = 0;
  int n_err = 0;

  int unsigned exp_q[$];
  int unsigned obs_q[$];

  // Results of the last run_word call.
  int done_cnt, done_gap, first_valid, unstable, flag_bad;

  always #5 clk = ~clk;

  hex_ascii_streamer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_char (out_char),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
  );

  hex_ascii_streamer #(
    .DATA_WIDTH (8),
    .ASCII_SIZE (8),
    .APPEND_CRLF(1'b0)
  ) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (n_in_valid),
    .in_data  (n_in_data),
    .in_ready (n_in_ready),
    .out_valid(n_out_valid),
    .out_char (n_out_char),
    .out_ready(n_out_ready),
    .busy     (n_busy),
    .done     (n_done)
  );

  // Reference: hex text of the low 'digits' nibbles, MSB first, plus optional CR LF.
  function automatic void push_expected(input logic [W-1:0] data, input int digits,
                                        input bit crlf);
    for (int i = digits - 1; i >= 0; i--) begin
      int unsigned nib;
      nib = int'(data[4*i +: 4]);
      exp_q.push_back(nib < 10 ? 48 + nib : 55 + nib);
    end
    if (crlf) begin
      exp_q.push_back(13);
      exp_q.push_back(10);
    end
  endfunction

  function automatic int count_diffs();
    int d;
    int n;
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    d = (obs_q.size() > exp_q.size()) ? obs_q.size() - exp_q.size()
                                      : exp_q.size() - obs_q.size();
    for (int i = 0; i < n; i++) if (obs_q[i] != exp_q[i]) d++;
    return d;
  endfunction

  function automatic logic [W-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Streams one word through the wide instance, collecting accepted characters.
  task automatic run_word(input logic [W-1:0] data, input int stall_pct);
    int         cyc;
    int         last_acc;
    int         done_c;
    bit         stalled;
    logic [7:0] held;
    obs_q.delete();
    done_cnt = 0; done_gap = -1; first_valid = -1; unstable = 0; flag_bad = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = data; out_ready = 1'b0;
    cyc = 0;
    while (!in_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = rand_word();
    last_acc = -1; done_c = -1; stalled = 1'b0; held = '0;
    for (int c = 0; c < 600; c++) begin
      if (done) begin
        done_cnt++;
        if (done_c < 0) begin
          done_c   = c;
          done_gap = c - last_acc;
        end
      end
      if (done_c >= 0 && c >= done_c + 3) break;
      if (out_valid && first_valid < 0) first_valid = c;
      if (out_valid && (!busy || in_ready)) flag_bad++;
      if (done_c >= 0 && out_valid) flag_bad++;
      if (stalled && (!out_valid || out_char !== held)) unstable++;
      out_ready = ($urandom_range(99) >= stall_pct);
      if (out_valid) begin
        held    = out_char;
        stalled = !out_ready;
        if (out_ready) begin
          obs_q.push_back(int'(out_char));
          last_acc = c;
        end
      end else begin
        stalled = 1'b0;
      end
      if (c % 50 == 7) in_data = rand_word();
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++;
      $display("FAIL reset_out_valid: got %b, want 0", out_valid); end
    n_vec++; if (out_char !== 8'h00) begin n_err++;
      $display("FAIL reset_out_char: got %0d, want 0", out_char); end
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++;
      $display("FAIL reset_busy_done: got %b%b, want 00", busy, done); end
    n_vec++; if (n_out_valid !== 1'b0 || n_out_char !== 8'h00) begin n_err++;
      $display("FAIL reset_narrow: got %b/%0d, want 0/0", n_out_valid, n_out_char); end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b1) begin n_err++;
      $display("FAIL reset_in_ready: got %b, want 1", in_ready); end
  endtask

  task automatic test_known_vector();
    logic [W-1:0] d;
    d = 128'h00112233445566778899AABBCCDDEEFF;
    exp_q.delete();
    push_expected(d, 32, 1'b1);
    run_word(d, 0);
    n_vec++; if (count_diffs() !== 0) begin n_err++;
      $display("FAIL known_chars: %0d of %0d chars differ (got %0d chars), want 0",
               count_diffs(), exp_q.size(), obs_q.size()); end
    n_vec++; if (first_valid !== 0) begin n_err++;
      $display("FAIL known_latency: first char %0d cycles late, want 0", first_valid); end
    n_vec++; if (done_cnt !== 1 || done_gap !== 1) begin n_err++;
      $display("FAIL known_done: pulses %0d gap %0d, want 1 and 1", done_cnt, done_gap); end
    n_vec++; if (flag_bad !== 0) begin n_err++;
      $display("FAIL known_flags: %0d bad busy/in_ready cycles, want 0", flag_bad); end
  endtask

  task automatic test_all_nibbles();
    logic [W-1:0] d;
    logic [15:0]  seen;
    int           bad;
    d = 128'h0123456789ABCDEFFEDCBA9876543210;
    exp_q.delete();
    push_expected(d, 32, 1'b1);
    run_word(d, 30);
    seen = '0; bad = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i] >= 48 && obs_q[i] <= 57)      seen[obs_q[i] - 48] = 1'b1;
      else if (obs_q[i] >= 65 && obs_q[i] <= 70) seen[obs_q[i] - 55] = 1'b1;
      else if (obs_q[i] != 13 && obs_q[i] != 10) bad++;
    end
    n_vec++; if (count_diffs() !== 0) begin n_err++;
      $display("FAIL nibbles_chars: %0d chars differ, want 0", count_diffs()); end
    n_vec++; if (seen !== 16'hFFFF || bad !== 0) begin n_err++;
      $display("FAIL nibbles_set: seen %h stray %0d, want ffff and 0", seen, bad); end
    n_vec++; if (unstable !== 0) begin n_err++;
      $display("FAIL nibbles_stall: %0d unstable cycles, want 0", unstable); end
  endtask

  task automatic test_random();
    logic [W-1:0] d;
    for (int k = 0; k < 6; k++) begin
      d = rand_word();
      exp_q.delete();
      push_expected(d, 32, 1'b1);
      run_word(d, (k * 15) % 70);
      n_vec++; if (count_diffs() !== 0 || unstable !== 0) begin n_err++;
        $display("FAIL random_%0d: %0d diffs %0d unstable, want 0 and 0", k, count_diffs(),
                 unstable); end
      n_vec++; if (done_cnt !== 1 || done_gap !== 1 || flag_bad !== 0) begin n_err++;
        $display("FAIL random_done_%0d: pulses %0d gap %0d bad %0d, want 1 1 0", k, done_cnt,
                 done_gap, flag_bad); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    int  started, gap, dcnt;
    bit  prev_busy;
    a = rand_word();
    b = rand_word();
    exp_q.delete();
    push_expected(a, 32, 1'b1);
    push_expected(b, 32, 1'b1);
    obs_q.delete();
    started = 0; gap = 0; dcnt = 0; prev_busy = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = a; out_ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (done) dcnt++;
      if (busy && !prev_busy) started++;
      if (started == 1 && !busy) gap++;
      if (started == 1) in_data = b;
      if (started == 2) in_valid = 1'b0;
      if (out_valid) obs_q.push_back(int'(out_char));
      prev_busy = busy;
      if (dcnt == 2) break;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_vec++; if (count_diffs() !== 0) begin n_err++;
      $display("FAIL b2b_chars: %0d diffs (got %0d chars), want 0", count_diffs(),
               obs_q.size()); end
    n_vec++; if (gap !== 1) begin n_err++;
      $display("FAIL b2b_gap: %0d idle cycles between words, want 1", gap); end
    n_vec++; if (dcnt !== 2 || started !== 2) begin n_err++;
      $display("FAIL b2b_done: %0d done %0d starts, want 2 and 2", dcnt, started); end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] d;
    int acc, cyc, bad;
    d = rand_word();
    exp_q.delete();
    push_expected(d, 32, 1'b1);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; out_ready = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    acc = 0; cyc = 0;
    while (acc < 5 && cyc < 100) begin
      if (out_valid) acc++;
      @(negedge clk);
      cyc++;
    end
    n_vec++; if (out_char !== 8'(exp_q[5]) || out_valid !== 1'b1) begin n_err++;
      $display("FAIL midrst_sixth: got %0d valid %b, want %0d valid 1", out_char, out_valid,
               exp_q[5]); end
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0 || out_char !== 8'h00) begin n_err++;
      $display("FAIL midrst_outputs: got valid %b char %0d, want 0 0", out_valid, out_char); end
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++;
      $display("FAIL midrst_status: got busy %b done %b, want 0 0", busy, done); end
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid || done || busy) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++;
      $display("FAIL midrst_quiet: %0d active cycles after release, want 0", bad); end
    d = rand_word();
    exp_q.delete();
    push_expected(d, 32, 1'b1);
    run_word(d, 20);
    n_vec++; if (count_diffs() !== 0 || done_cnt !== 1) begin n_err++;
      $display("FAIL midrst_restart: %0d diffs %0d done, want 0 and 1", count_diffs(),
               done_cnt); end
  endtask

  task automatic test_narrow();
    logic [W-1:0] d;
    logic [7:0]   held;
    bit           tog, stalled;
    int           cyc, dcnt, unst;
    d = '0;
    d[7:0] = 8'hF0;
    exp_q.delete();
    push_expected(d, 2, 1'b0);
    obs_q.delete();
    @(negedge clk);
    n_in_valid = 1'b1; n_in_data = 8'hF0; n_out_ready = 1'b0;
    cyc = 0;
    while (!n_in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    n_in_valid = 1'b0; n_in_data = 8'h5A;
    tog = 1'b1; stalled = 1'b0; held = '0; dcnt = 0; unst = 0;
    for (int c = 0; c < 20; c++) begin
      if (n_done) dcnt++;
      if (stalled && (!n_out_valid || n_out_char !== held)) unst++;
      n_out_ready = tog;
      tog = !tog;
      if (n_out_valid) begin
        held    = n_out_char;
        stalled = !n_out_ready;
        if (n_out_ready) obs_q.push_back(int'(n_out_char));
      end else begin
        stalled = 1'b0;
      end
      @(negedge clk);
    end
    n_out_ready = 1'b0;
    n_vec++; if (count_diffs() !== 0) begin n_err++;
      $display("FAIL narrow_chars: %0d diffs (got %0d chars), want 0", count_diffs(),
               obs_q.size()); end
    n_vec++; if (unst !== 0) begin n_err++;
      $display("FAIL narrow_stall: %0d unstable cycles, want 0", unst); end
    n_vec++; if (dcnt !== 1) begin n_err++;
      $display("FAIL narrow_done: %0d pulses, want 1", dcnt); end
  endtask

  initial begin
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    n_in_valid = 1'b0; n_in_data = '0; n_out_ready = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_known_vector();
    test_all_nibbles();
    test_random();
    test_back_to_back();
    test_mid_reset();
    test_narrow();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hex_ascii_streamer.md
HEX_ASCII_STREAMER -- requirements
Module: hex_ascii_streamer

Interface
REQ-001 Parameter DATA_WIDTH, default 128, width of the block to print; SHALL be a multiple of 4.
REQ-002 Parameter ASCII_SIZE, default 8, width of one output character.
REQ-003 Parameter APPEND_CRLF, default 1, appends CR (13) then LF (10) after the hex digits when 1.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  word offered.
REQ-007 in_data  input  DATA_WIDTH  word to print, e.g. AES ciphertext.
REQ-008 in_ready  output  1  block can accept a word.
REQ-009 out_valid  output  1  character on out_char is valid.
REQ-010 out_char  output  ASCII_SIZE  ASCII character for the UART transmitter.
REQ-011 out_ready  input  1  downstream consumes out_char this cycle.
REQ-012 busy  output  1  a word is being streamed.
REQ-013 done  output  1  one-cycle pulse after the last character is accepted.

Function
REQ-014 States SHALL be IDLE, HEX, CR, LF.
REQ-015 in_ready SHALL be 1 only in IDLE; a word transfers on in_valid & in_ready.
REQ-016 On transfer, in_data SHALL be latched into a shift register, the digit counter set to DATA_WIDTH/4-1, and the state set to HEX on the next edge.
REQ-017 In HEX, out_valid SHALL be 1 and out_char SHALL be the ASCII hex code of the most significant unsent nibble: 0-9 map to 48-57 and 10-15 map to 65-70 (uppercase).
REQ-018 Digits SHALL be emitted MSB nibble first: DATA_WIDTH/4 characters per word.
REQ-019 A character SHALL advance only on out_valid & out_ready; out_char SHALL hold stable while out_ready=0.
REQ-020 On acceptance of the last digit (counter=0), the state SHALL go to CR if APPEND_CRLF=1, else to IDLE.
REQ-021 CR SHALL emit 13 and go to LF on acceptance; LF SHALL emit 10 and go to IDLE on acceptance.
REQ-022 done SHALL pulse for exactly one cycle, in the cycle after the final character is accepted.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 out_valid SHALL be 0 in IDLE; a new word is not accepted in the same cycle its predecessor's last character is accepted (minimum one IDLE cycle).
REQ-025 Back-to-back throughput with out_ready held at 1 SHALL be one character per cycle, so first-character latency is 1 cycle after the input transfer.
REQ-026 The digit counter SHALL be $clog2(DATA_WIDTH/4) bits wide and SHALL NOT wrap; it is only decremented when it is nonzero.
REQ-027 in_data changes outside a transfer SHALL have no effect.

Reset
REQ-028 Asserting rst_n=0 SHALL immediately force: state IDLE, in_ready 1 after release, out_valid 0, out_char 0, busy 0, done 0, counter 0, shift register 0.
REQ-029 Reset asserted mid-word SHALL abandon the word with no further characters and no done pulse.

Structure
REQ-030 A shared package SHALL hold the state enum and the constants ASCII_CR=13, ASCII_LF=10, ASCII_0=48, ASCII_A=65.
REQ-031 One sub-module, nibble_ascii_lut (4-bit in, ASCII_SIZE out, combinational), SHALL perform the digit mapping.

Verification
REQ-032 Reset, then send 128'h00112233445566778899AABBCCDDEEFF with out_ready=1 -> 34 characters "00112233445566778899AABBCCDDEEFF", then 13, then 10, with done on the cycle after 10.
REQ-033 DATA_WIDTH=8, APPEND_CRLF=0, in_data=8'hF0, out_ready toggling 1/0 -> exactly "F0", with out_char stable during stalls and one done pulse.
REQ-034 in_valid held high across two words -> second word is accepted only after at least one IDLE cycle; no characters are lost or duplicated.
REQ-035 rst_n low after the 5th digit -> outputs are 0 immediately, no done pulse; a new word after release streams from its first digit.
REQ-036 All nibbles 0..F -> out_char values 48..57 and 65..70, with no other values appearing.
